// File: rtl/elevator_pkg.sv
// Shared elevator encodings: travel direction codes, scheduler FSM states and the default
// floor count. Also used by the motor/door controller and the display blocks.
package elevator_pkg;
   localparam int FLOORS_DEFAULT = 4;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DOWN = 2'b10
   } sched_state_e;
endpackage

// File: rtl/floor_search.sv
// Combinational scan of a request mask about the current floor: nearest pending floor
// above, nearest pending floor below, and whether the current floor itself is pending.
module floor_search #(
   parameter int FLOORS  = 4,
   parameter int FLOOR_W = $clog2(FLOORS)
) (
   input  logic [FLOORS-1:0]  mask,
   input  logic [FLOOR_W-1:0] cur_floor,
   output logic               above_found,
   output logic [FLOOR_W-1:0] above_floor,
   output logic               below_found,
   output logic [FLOOR_W-1:0] below_floor,
   output logic               here
);
   always_comb begin
      above_found = 1'b0;
      above_floor = '0;
      below_found = 1'b0;
      below_floor = '0;
      here        = 1'b0;
      // Scan downward so the last hit is the lowest floor above the car.
      for (int i = FLOORS - 1; i >= 0; i--) begin
         if (mask[i] && (i > int'(cur_floor))) begin
            above_found = 1'b1;
            above_floor = FLOOR_W'(i);
         end
      end
      // Scan upward so the last hit is the highest floor below the car.
      for (int i = 0; i < FLOORS; i++) begin
         if (mask[i] && (i < int'(cur_floor))) begin
            below_found = 1'b1;
            below_floor = FLOOR_W'(i);
         end
         if (mask[i] && (i == int'(cur_floor)))
            here = 1'b1;
      end
   end
endmodule

// File: rtl/floor_call_scheduler.sv
// Latches floor call pulses into a pending mask and runs a SCAN policy against the car's
// current floor, presenting a registered target floor and travel direction.
module floor_call_scheduler
   import elevator_pkg::*;
#(
   parameter int FLOORS  = FLOORS_DEFAULT,
   parameter int FLOOR_W = $clog2(FLOORS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  call_pulse,
   input  logic [FLOOR_W-1:0] cur_floor,
   input  logic               arrived,
   output logic [FLOORS-1:0]  pending,
   output logic [FLOOR_W-1:0] target_floor,
   output logic               target_valid,
   output logic [1:0]         dir
);
   logic [FLOORS-1:0]  pending_q, pending_d, clr_mask;
   sched_state_e       state_q, state_d;
   logic [FLOOR_W-1:0] target_q, target_d;
   logic               valid_q, valid_d;
   logic [1:0]         dir_q, dir_d;

   logic               above_found, below_found, here;
   logic [FLOOR_W-1:0] above_floor, below_floor;
   logic [FLOOR_W-1:0] dist_up, dist_dn;
   logic               floor_legal;

   floor_search #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_search (
      .mask        (pending_q),
      .cur_floor   (cur_floor),
      .above_found (above_found),
      .above_floor (above_floor),
      .below_found (below_found),
      .below_floor (below_floor),
      .here        (here)
   );

   // Clear is applied after set so a press at the floor the car is opening at is dropped.
   always_comb begin
      clr_mask = '0;
      for (int i = 0; i < FLOORS; i++)
         clr_mask[i] = arrived && (cur_floor == FLOOR_W'(i));
      pending_d = (pending_q | call_pulse) & ~clr_mask;
   end

   assign floor_legal = int'(cur_floor) < FLOORS;
   assign dist_up     = above_floor - cur_floor;
   assign dist_dn     = cur_floor - below_floor;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      valid_d  = 1'b0;
      if (floor_legal) begin
         unique case (state_q)
            ST_UP: begin
               if (above_found) begin
                  state_d = ST_UP;   target_d = above_floor; valid_d = 1'b1;
               end else if (below_found) begin
                  state_d = ST_DOWN; target_d = below_floor; valid_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  if (here) begin target_d = cur_floor; valid_d = 1'b1; end
               end
            end
            ST_DOWN: begin
               if (below_found) begin
                  state_d = ST_DOWN; target_d = below_floor; valid_d = 1'b1;
               end else if (above_found) begin
                  state_d = ST_UP;   target_d = above_floor; valid_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  if (here) begin target_d = cur_floor; valid_d = 1'b1; end
               end
            end
            default: begin
               if (here) begin
                  state_d = ST_IDLE; target_d = cur_floor; valid_d = 1'b1;
               end else if (above_found && (!below_found || dist_up <= dist_dn)) begin
                  state_d = ST_UP;   target_d = above_floor; valid_d = 1'b1;
               end else if (below_found) begin
                  state_d = ST_DOWN; target_d = below_floor; valid_d = 1'b1;
               end
            end
         endcase
      end
      unique case (state_d)
         ST_UP:   dir_d = DIR_UP;
         ST_DOWN: dir_d = DIR_DOWN;
         default: dir_d = DIR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         state_q   <= ST_IDLE;
         target_q  <= '0;
         valid_q   <= 1'b0;
         dir_q     <= DIR_IDLE;
      end else begin
         pending_q <= pending_d;
         state_q   <= state_d;
         target_q  <= target_d;
         valid_q   <= valid_d;
         dir_q     <= dir_d;
      end
   end

   assign pending      = pending_q;
   assign target_floor = target_q;
   assign target_valid = valid_q;
   assign dir          = dir_q;
endmodule

// File: tb/tb_floor_call_scheduler.sv
// Directed bench for floor_call_scheduler: latency, SCAN ordering, same-cycle set/clear,
// nearest-floor selection from idle and asynchronous reset during travel.
module tb_floor_call_scheduler;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] call_pulse;
   logic [1:0] cur_floor;
   logic       arrived;
   logic [3:0] pending;
   logic [1:0] target_floor;
   logic       target_valid;
   logic [1:0] dir;

   int pass_cnt = 0;
   int total    = 0;

   floor_call_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .call_pulse   (call_pulse),
      .cur_floor    (cur_floor),
      .arrived      (arrived),
      .pending      (pending),
      .target_floor (target_floor),
      .target_valid (target_valid),
      .dir          (dir)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are driven and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; call_pulse = '0; arrived = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; call_pulse = '0; arrived = 1'b0; cur_floor = '0;
      tick();
      total++;
      if ({pending, target_floor, target_valid, dir} !== 9'b0)
         $display("FAIL reset_state got p=%b t=%0d v=%b d=%b want all zero",
                  pending, target_floor, target_valid, dir);
      else pass_cnt++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_latency();
      cur_floor = 2'd0;
      call_pulse = 4'b1000;
      tick();
      call_pulse = '0;
      total++;
      if (pending !== 4'b1000 || target_valid !== 1'b0)
         $display("FAIL latency_n1 got p=%b v=%b want p=1000 v=0", pending, target_valid);
      else pass_cnt++;
      tick();
      total++;
      if ({target_valid, dir, target_floor} !== {1'b1, 2'b01, 2'd3})
         $display("FAIL latency_n2 got v=%b d=%b t=%0d want v=1 d=01 t=3",
                  target_valid, dir, target_floor);
      else pass_cnt++;
   endtask

   // Continues from test_latency: car travelling UP toward 3.
   task automatic test_scan_up();
      cur_floor = 2'd1;
      call_pulse = 4'b0101;
      tick();
      call_pulse = '0;
      tick();
      total++;
      if ({pending, target_valid, dir, target_floor} !== {4'b1101, 1'b1, 2'b01, 2'd2})
         $display("FAIL scan_up_f1 got p=%b v=%b d=%b t=%0d want p=1101 v=1 d=01 t=2",
                  pending, target_valid, dir, target_floor);
      else pass_cnt++;
      cur_floor = 2'd2; arrived = 1'b1;
      tick();
      arrived = 1'b0;
      tick();
      total++;
      if ({pending, dir, target_floor} !== {4'b1001, 2'b01, 2'd3})
         $display("FAIL scan_up_f2 got p=%b d=%b t=%0d want p=1001 d=01 t=3",
                  pending, dir, target_floor);
      else pass_cnt++;
      cur_floor = 2'd3; arrived = 1'b1;
      tick();
      arrived = 1'b0;
      tick();
      total++;
      if ({pending, target_valid, dir, target_floor} !== {4'b0001, 1'b1, 2'b10, 2'd0})
         $display("FAIL scan_reverse got p=%b v=%b d=%b t=%0d want p=0001 v=1 d=10 t=0",
                  pending, target_valid, dir, target_floor);
      else pass_cnt++;
   endtask

   task automatic test_idle_here();
      do_reset();
      cur_floor = 2'd2;
      call_pulse = 4'b0100;
      tick();
      call_pulse = '0;
      tick();
      total++;
      if ({target_valid, dir, target_floor} !== {1'b1, 2'b00, 2'd2})
         $display("FAIL idle_here got v=%b d=%b t=%0d want v=1 d=00 t=2",
                  target_valid, dir, target_floor);
      else pass_cnt++;
      arrived = 1'b1;
      tick();
      arrived = 1'b0;
      tick();
      total++;
      if (pending !== 4'b0000 || target_valid !== 1'b0)
         $display("FAIL idle_served got p=%b v=%b want p=0000 v=0", pending, target_valid);
      else pass_cnt++;
   endtask

   task automatic test_same_cycle();
      cur_floor = 2'd2;
      call_pulse = 4'b0110; arrived = 1'b1;
      tick();
      call_pulse = '0; arrived = 1'b0;
      total++;
      if (pending !== 4'b0010)
         $display("FAIL set_clear_same got p=%b want p=0010", pending);
      else pass_cnt++;
      // Re-press of an already pending floor leaves the mask unchanged.
      call_pulse = 4'b0010;
      tick();
      call_pulse = '0;
      total++;
      if (pending !== 4'b0010)
         $display("FAIL repress got p=%b want p=0010", pending);
      else pass_cnt++;
   endtask

   task automatic test_nearest();
      do_reset();
      cur_floor = 2'd1;
      call_pulse = 4'b1001;
      tick();
      call_pulse = '0;
      tick();
      total++;
      if ({target_valid, dir, target_floor} !== {1'b1, 2'b10, 2'd0})
         $display("FAIL nearest_down got v=%b d=%b t=%0d want v=1 d=10 t=0",
                  target_valid, dir, target_floor);
      else pass_cnt++;
      do_reset();
      cur_floor = 2'd2;
      call_pulse = 4'b1010;
      tick();
      call_pulse = '0;
      tick();
      total++;
      if ({target_valid, dir, target_floor} !== {1'b1, 2'b01, 2'd3})
         $display("FAIL nearest_tie got v=%b d=%b t=%0d want v=1 d=01 t=3",
                  target_valid, dir, target_floor);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_travel();
      do_reset();
      cur_floor = 2'd1;
      call_pulse = 4'b1101;
      tick();
      call_pulse = 4'b0010;
      tick();
      call_pulse = '0;
      tick();
      total++;
      if ({pending, target_valid, dir, target_floor} !== {4'b1111, 1'b1, 2'b01, 2'd2})
         $display("FAIL pre_reset got p=%b v=%b d=%b t=%0d want p=1111 v=1 d=01 t=2",
                  pending, target_valid, dir, target_floor);
      else pass_cnt++;
      #2 reset = 1'b1;
      #1;
      total++;
      if ({pending, target_floor, target_valid, dir} !== 9'b0)
         $display("FAIL async_reset got p=%b t=%0d v=%b d=%b want all zero",
                  pending, target_floor, target_valid, dir);
      else pass_cnt++;
      tick();
      reset = 1'b0;
      tick();
      tick();
      total++;
      if ({pending, target_valid, dir} !== 7'b0)
         $display("FAIL post_reset got p=%b v=%b d=%b want p=0000 v=0 d=00",
                  pending, target_valid, dir);
      else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1; call_pulse = '0; cur_floor = '0; arrived = 1'b0;
      #2;
      test_reset();
      test_latency();
      test_scan_up();
      test_idle_here();
      test_same_cycle();
      test_nearest();
      test_reset_mid_travel();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
